// File: rtl/blk_rr_sched_if.sv
// Request/grant/result bundle between NREQ requesters and the shared
// iterative invert engine scheduler.
interface blk_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int CW   = 5
) ();
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] op_data;
    logic [NREQ*CW-1:0] op_cnt;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               done;
    logic [IW-1:0]      done_id;
    logic [DW-1:0]      result;

    modport master (
        output req, op_data, op_cnt,
        input  gnt, busy, done, done_id, result
    );

    modport slave (
        input  req, op_data, op_cnt,
        output gnt, busy, done, done_id, result
    );
endinterface

// File: rtl/blk_rr_sched.sv
// Round-robin scheduler in front of a single iterative invert engine.
// Define BLK_SCHED_FIXED_PRIO_EN to replace round-robin with lowest-index-wins.
module blk_rr_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int CW   = 5
) (
    input  logic         clk,
    input  logic         rst,
    blk_rr_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [IW-1:0]   win_q, win_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [IW-1:0]   done_id_q, done_id_d;
    logic [DW-1:0]   result_q, result_d;

    logic            found_s;
    logic [IW-1:0]   win_s;
    logic [IW-1:0]   idx_s;

`ifdef BLK_SCHED_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest set index is the last to win.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IW{1'b0}};
        idx_s   = {IW{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                found_s = 1'b1;
                win_s   = IW'(k);
            end else begin
                found_s = found_s;
            end
        end
    end
`else
    // Round-robin: first set request starting one past the last winner.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IW{1'b0}};
        idx_s   = {IW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = IW'((int'(ptr_q) + k) % NREQ);
            if (!found_s && bus.req[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end
`endif

    // Next-state and registered-output logic for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        win_d     = win_q;
        gnt_d     = {NREQ{1'b0}};
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_BUSY;
                    acc_d   = bus.op_data[int'(win_s)*DW +: DW];
                    rem_d   = bus.op_cnt[int'(win_s)*CW +: CW];
                    win_d   = win_s;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
`ifdef BLK_SCHED_FIXED_PRIO_EN
                    ptr_d   = ptr_q;
`else
                    ptr_d   = win_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (rem_q != {CW{1'b0}}) begin
                    acc_d = ~acc_q;
                    rem_d = rem_q - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    result_d  = acc_q;
                    done_id_d = win_q;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IW'(NREQ - 1);
            acc_q     <= {DW{1'b0}};
            rem_q     <= {CW{1'b0}};
            win_q     <= {IW{1'b0}};
            gnt_q     <= {NREQ{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= {IW{1'b0}};
            result_q  <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;

endmodule

// File: tb/tb_blk_rr_sched.sv
// Directed self-checking bench for blk_rr_sched (NREQ=4, DW=8, CW=5).
module tb_blk_rr_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    blk_rr_sched_if #(.NREQ(4), .DW(8), .CW(5)) bus ();

    blk_rr_sched #(.NREQ(4), .DW(8), .CW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_gnt(input int budget, output logic [3:0] g, output int e);
        g = 4'b0000;
        e = -1000;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.gnt != 4'b0000) begin
                g = bus.gnt;
                e = edge_n;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int e, output logic [7:0] r, output logic [1:0] id);
        e  = -1000;
        r  = 8'h00;
        id = 2'd0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.done) begin
                e  = edge_n;
                r  = bus.result;
                id = bus.done_id;
                break;
            end
        end
    endtask

    task automatic post(input int idx, input logic [7:0] data, input logic [4:0] cnt);
        bus.req[idx]            = 1'b1;
        bus.op_data[idx*8 +: 8] = data;
        bus.op_cnt[idx*5 +: 5]  = cnt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", bus.gnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.done_id !== 2'd0) $display("FAIL rst_done_id: got %0d want 0", bus.done_id); else n_pass++;
        n_checks++; if (bus.result !== 8'h00) $display("FAIL rst_result: got %h want 00", bus.result); else n_pass++;
    endtask

    task automatic test_single();
        logic [3:0] g; int eg; int ed; logic [7:0] r; logic [1:0] id;
        post(2, 8'hA5, 5'd3);
        wait_gnt(20, g, eg);
        bus.req = 4'b0000;
        n_checks++; if (g !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", g); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt); else n_pass++;
        wait_done(40, ed, r, id);
        n_checks++; if (ed - eg !== 4) $display("FAIL single_latency: got %0d want 4", ed - eg); else n_pass++;
        n_checks++; if (r !== 8'h5A) $display("FAIL single_result: got %h want 5a", r); else n_pass++;
        n_checks++; if (id !== 2'd2) $display("FAIL single_done_id: got %0d want 2", id); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL single_end: got done=%b busy=%b want 0 0", bus.done, bus.busy); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.result !== 8'h5A) $display("FAIL single_hold: got %h want 5a", bus.result); else n_pass++;
    endtask

    task automatic test_counts();
        logic [3:0] g; int eg; int ed; logic [7:0] r; logic [1:0] id;
        post(1, 8'h3C, 5'd0);
        wait_gnt(20, g, eg);
        bus.req = 4'b0000;
        wait_done(40, ed, r, id);
        n_checks++; if (ed - eg !== 1) $display("FAIL zero_latency: got %0d want 1", ed - eg); else n_pass++;
        n_checks++; if (r !== 8'h3C) $display("FAIL zero_result: got %h want 3c", r); else n_pass++;
        post(0, 8'h3C, 5'd20);
        wait_gnt(20, g, eg);
        bus.req = 4'b0000;
        wait_done(60, ed, r, id);
        n_checks++; if (ed - eg !== 21) $display("FAIL even_latency: got %0d want 21", ed - eg); else n_pass++;
        n_checks++; if (r !== 8'h3C || id !== 2'd0) $display("FAIL even_result: got %h/%0d want 3c/0", r, id); else n_pass++;
        post(3, 8'h01, 5'd31);
        wait_gnt(20, g, eg);
        bus.req = 4'b0000;
        wait_done(60, ed, r, id);
        n_checks++; if (ed - eg !== 32) $display("FAIL max_latency: got %0d want 32", ed - eg); else n_pass++;
        n_checks++; if (r !== 8'hFE || id !== 2'd3) $display("FAIL max_result: got %h/%0d want fe/3", r, id); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [3:0] g; int eg; int prev; int ed; logic [7:0] r; logic [1:0] id;
        int exp_idx [5];
`ifdef BLK_SCHED_FIXED_PRIO_EN
        exp_idx = '{0, 0, 0, 0, 0};
`else
        exp_idx = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        prev = 0;
        for (int i = 0; i < 4; i++) post(i, 8'h11 * (i + 1), 5'd1);
        for (int n = 0; n < 5; n++) begin
            wait_gnt(20, g, eg);
            if (n == 4) bus.req = 4'b0000;
            n_checks++;
            if (g !== (4'b0001 << exp_idx[n])) $display("FAIL fair_gnt%0d: got %b want idx %0d", n, g, exp_idx[n]);
            else n_pass++;
            if (n > 0) begin
                n_checks++;
                if (eg - prev !== 4) $display("FAIL fair_gap%0d: got %0d want 4", n, eg - prev);
                else n_pass++;
            end
            prev = eg;
        end
        wait_done(20, ed, r, id);
        n_checks++; if (r !== 8'hEE || id !== 2'd0) $display("FAIL fair_result: got %h/%0d want ee/0", r, id); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] g; int eg0; int eg1; int ed; logic [7:0] r; logic [1:0] id;
        post(0, 8'h0F, 5'd5);
        wait_gnt(20, g, eg0);
        bus.req = 4'b0000;
        post(1, 8'h77, 5'd2);
        wait_gnt(30, g, eg1);
        bus.req = 4'b0000;
        n_checks++; if (g !== 4'b0010) $display("FAIL lockout_gnt: got %b want 0010", g); else n_pass++;
        n_checks++; if (eg1 - eg0 !== 8) $display("FAIL lockout_gap: got %0d want 8", eg1 - eg0); else n_pass++;
        wait_done(20, ed, r, id);
        n_checks++; if (r !== 8'h77 || id !== 2'd1) $display("FAIL lockout_result: got %h/%0d want 77/1", r, id); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [3:0] g; int eg; int ed; logic [7:0] r; logic [1:0] id;
        post(0, 8'hC3, 5'd5);
        wait_gnt(20, g, eg);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        post(3, 8'h96, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b want 0", bus.done); else n_pass++;
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.done_id !== 2'd0 || bus.result !== 8'h00)
            $display("FAIL midrst_outputs: got gnt=%b busy=%b id=%0d res=%h want all 0", bus.gnt, bus.busy, bus.done_id, bus.result);
        else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b1000) $display("FAIL midrst_regrant: got %b want 1000", bus.gnt); else n_pass++;
        eg = edge_n;
        bus.req = 4'b0000;
        wait_done(20, ed, r, id);
        n_checks++; if (ed - eg !== 1) $display("FAIL midrst_latency: got %0d want 1", ed - eg); else n_pass++;
        n_checks++; if (r !== 8'h96 || id !== 2'd3) $display("FAIL midrst_result: got %h/%0d want 96/3", r, id); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.req     = 4'b0000;
        bus.op_data = 32'h0000_0000;
        bus.op_cnt  = 20'h00000;
        test_reset();
        test_single();
        test_counts();
        test_fairness();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
